// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package imem_fetch_pkg;

  localparam int IMEM_N = 16;
  localparam int IMEM_R = 5;

  localparam logic [IMEM_N-1:0] HALT_WORD = 16'hFFFF;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [IMEM_R-1:0] pc;
    logic [IMEM_N-1:0] instr;
  } fetch_entry_t;

  // The PC is exactly IMEM_R bits wide, so the increment wraps 31 -> 0 on its own.
  function automatic logic [IMEM_R-1:0] pc_next(input logic [IMEM_R-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries between imem and decode.
module fetch_fifo
  import imem_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  fetch_entry_t           i_data,
  output logic [$clog2(DEPTH):0] o_count,
  output fetch_entry_t           o_head,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_head;
  logic [AW-1:0]  r_tail;
  logic [AW:0]    r_count;
  logic           w_pop_ok;
  logic           w_push_ok;

  assign w_pop_ok  = i_pop && (r_count != '0);
  assign w_push_ok = i_push && ((r_count != FULL_COUNT) || w_pop_ok);

  // Pointer and occupancy bookkeeping; a flush empties the FIFO regardless of push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop_ok) begin
        r_head <= r_head + 1'b1;
      end
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop_ok && !w_push_ok) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Entry storage needs no reset: the head is only looked at while the count is nonzero.
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) begin
      r_mem[r_tail] <= i_data;
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_COUNT);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, feeds the fetch buffer, handles redirects and HALT.
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter int          N        = IMEM_N,
  parameter int          R        = IMEM_R,
  parameter int          DEPTH    = 2,
  parameter logic [R-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [R-1:0] o_imem_addr,
  input  logic [N-1:0] i_imem_rdata,
  input  logic         i_redirect_valid,
  input  logic [R-1:0] i_redirect_pc,
  output logic         o_instr_valid,
  output logic [N-1:0] o_instr,
  output logic [R-1:0] o_instr_pc,
  input  logic         i_instr_ready,
  output logic         o_halted
);

  fetch_state_t            r_state;
  fetch_state_t            w_state_next;
  logic [R-1:0]            r_pc;
  logic [R-1:0]            w_pc_next;
  logic                    w_dequeue;
  logic                    w_enqueue;
  logic                    w_is_halt;
  logic                    w_full;
  logic                    w_empty;
  logic [$clog2(DEPTH):0]  w_count;
  fetch_entry_t            w_push_entry;
  fetch_entry_t            w_head;

  assign w_push_entry.pc    = r_pc;
  assign w_push_entry.instr = i_imem_rdata;

  assign w_is_halt = (i_imem_rdata == HALT_WORD);
  assign w_dequeue = o_instr_valid && i_instr_ready;

  // A redirect suppresses any enqueue that cycle; a full buffer only accepts when decode drains it.
  assign w_enqueue = !i_redirect_valid && (r_state == FETCH) && i_en &&
                     (!w_full || w_dequeue);

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_enqueue),
    .i_pop   (w_dequeue),
    .i_flush (i_redirect_valid),
    .i_data  (w_push_entry),
    .o_count (w_count),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // Next state/PC: redirect wins; a HALT word is captured but freezes the PC.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    if (i_redirect_valid) begin
      w_state_next = FETCH;
      w_pc_next    = i_redirect_pc;
    end else if (w_enqueue) begin
      if (w_is_halt) begin
        w_state_next = HALTED;
      end else begin
        w_pc_next = pc_next(r_pc);
      end
    end
  end

  assign o_imem_addr   = r_pc;
  assign o_halted      = (r_state == HALTED);
  assign o_instr_valid = (w_count != '0);
  assign o_instr       = w_empty ? '0 : w_head.instr;
  assign o_instr_pc    = w_empty ? '0 : w_head.pc;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed scoreboard bench for imem_fetch_ctrl.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [4:0]  imemAddr;
  logic [15:0] imemRdata;
  logic        redirValid;
  logic [4:0]  redirPc;
  logic        instrValid;
  logic [15:0] instr;
  logic [4:0]  instrPc;
  logic        instrReady;
  logic        halted;

  logic [15:0] imem [32];
  logic [31:0] sb [$];
  int          vecCnt;
  int          failCnt;

  imem_fetch_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_en             (en),
    .o_imem_addr      (imemAddr),
    .i_imem_rdata     (imemRdata),
    .i_redirect_valid (redirValid),
    .i_redirect_pc    (redirPc),
    .o_instr_valid    (instrValid),
    .o_instr          (instr),
    .o_instr_pc       (instrPc),
    .i_instr_ready    (instrReady),
    .o_halted         (halted)
  );

  assign imemRdata = imem[imemAddr];

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expectEntry(input logic [4:0] pc, input logic [15:0] ins);
    sb.push_back({11'd0, pc, ins});
  endtask

  // Drive inputs for the coming rising edge, then score any handshake that edge will take.
  task automatic applyStimulus(input logic e, input logic r, input logic rv, input logic [4:0] rp);
    logic [31:0] expEntry;
    @(negedge clk);
    en         = e;
    instrReady = r;
    redirValid = rv;
    redirPc    = rp;
    #1;
    if (instrValid === 1'b1 && instrReady === 1'b1) begin
      checkOutput("sbHasEntry", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        expEntry = sb.pop_front();
        checkOutput("dequeue", {11'd0, instrPc, instr}, expEntry);
      end
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_valid"}, 32'(instrValid), 32'(0));
    checkOutput({tag, "_instr"}, 32'(instr), 32'(0));
    checkOutput({tag, "_pc"}, 32'(instrPc), 32'(0));
    checkOutput({tag, "_halted"}, 32'(halted), 32'(0));
    checkOutput({tag, "_addr"}, 32'(imemAddr), 32'(0));
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n      = 1'b0;
    en         = 1'b0;
    instrReady = 1'b0;
    redirValid = 1'b0;
    #1;
    checkResetValues("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecCnt     = 0;
    failCnt    = 0;
    rst_n      = 1'b1;
    en         = 1'b0;
    instrReady = 1'b0;
    redirValid = 1'b0;
    redirPc    = '0;
    for (int i = 0; i < 32; i++) imem[i] = 16'h1000 + 16'(i);
    imem[0]  = 16'h1111;
    imem[1]  = 16'h2222;
    imem[2]  = 16'h3333;
    imem[3]  = 16'hFFFF;
    imem[30] = 16'hAAAA;
    imem[31] = 16'hBBBB;

    #2 rst_n = 1'b0;
    #1 checkResetValues("initReset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic stream");
    expectEntry(5'd0, 16'h1111);
    expectEntry(5'd1, 16'h2222);
    expectEntry(5'd2, 16'h3333);
    applyStimulus(1, 1, 0, 0);
    checkOutput("preValid", 32'(instrValid), 32'(0));
    applyStimulus(1, 1, 0, 0);
    checkOutput("firstValid", 32'(instrValid), 32'(1));
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("streamEmpty", 32'(instrValid), 32'(0));
    checkOutput("enLowAddr", 32'(imemAddr), 32'(3));

    $display("[TB] backpressure");
    applyReset();
    expectEntry(5'd0, 16'h1111);
    expectEntry(5'd1, 16'h2222);
    expectEntry(5'd2, 16'h3333);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0);
      checkOutput("fullAddr", 32'(imemAddr), 32'(2));
      checkOutput("fullValid", 32'(instrValid), 32'(1));
      checkOutput("fullHeadPc", 32'(instrPc), 32'(0));
    end
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("bpDrained", 32'(instrValid), 32'(0));
    checkOutput("bpAddr", 32'(imemAddr), 32'(3));

    $display("[TB] wrap");
    expectEntry(5'd30, 16'hAAAA);
    expectEntry(5'd31, 16'hBBBB);
    expectEntry(5'd0, 16'h1111);
    applyStimulus(1, 1, 1, 5'd30);
    applyStimulus(1, 1, 0, 0);
    checkOutput("wrapGap", 32'(instrValid), 32'(0));
    checkOutput("wrapAddr", 32'(imemAddr), 32'(30));
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("wrapEmpty", 32'(instrValid), 32'(0));
    checkOutput("wrapPc", 32'(imemAddr), 32'(1));

    $display("[TB] redirect while full");
    expectEntry(5'd1, 16'h2222);
    expectEntry(5'd10, 16'h100A);
    expectEntry(5'd11, 16'h100B);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 1, 5'd10);
    applyStimulus(1, 1, 0, 0);
    checkOutput("flushGap", 32'(instrValid), 32'(0));
    checkOutput("flushAddr", 32'(imemAddr), 32'(10));
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("flushEmpty", 32'(instrValid), 32'(0));

    $display("[TB] halt");
    expectEntry(5'd2, 16'h3333);
    expectEntry(5'd3, 16'hFFFF);
    expectEntry(5'd0, 16'h1111);
    applyStimulus(1, 1, 1, 5'd2);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("preHalt", 32'(halted), 32'(0));
    applyStimulus(1, 1, 0, 0);
    checkOutput("haltRise", 32'(halted), 32'(1));
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, 0, 0);
      checkOutput("haltAddr", 32'(imemAddr), 32'(3));
      checkOutput("haltStay", 32'(halted), 32'(1));
      checkOutput("haltEmpty", 32'(instrValid), 32'(0));
    end
    applyStimulus(1, 1, 1, 5'd0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("haltClear", 32'(halted), 32'(0));
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("resumeEmpty", 32'(instrValid), 32'(0));

    $display("[TB] async reset");
    expectEntry(5'd1, 16'h2222);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    @(posedge clk);
    #2;
    checkOutput("preResetValid", 32'(instrValid), 32'(1));
    checkOutput("preResetInstr", 32'(instr), 32'(16'h3333));
    rst_n = 1'b0;
    #1;
    checkResetValues("asyncReset");

    checkOutput("sbDrained", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, failCnt);
    $finish;
  end

endmodule
